// File: rtl/bbox_frame_ctrl.sv
// Frame sequencer for the bounding-box pipeline: video timing tracking, pixel coordinates,
// accumulator clear/enable and the result handshake. Optional geometry checks: `BBOX_FRAME_CHECK_EN.
module bbox_frame_ctrl #(
    parameter int H_RES = 64,
    parameter int V_RES = 64,
    parameter int CW    = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          vid_de,
    input  logic          vid_hs,
    input  logic          vid_vs,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic          acc_clr,
    output logic          acc_en,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [7:0]    frame_cnt,
    output logic [7:0]    drop_cnt,
    output logic          busy,
    output logic          frame_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARMED  = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]    state;
    logic          de_q, vs_q, hs_q;
    logic [CW-1:0] x_cnt, y_cnt;
    logic          vs_rise, de_fall, hs_rise, last_line, handshake;

    assign vs_rise   = vid_vs & ~vs_q;
    assign de_fall   = ~vid_de & de_q;
    assign hs_rise   = vid_hs & ~hs_q;
    assign last_line = (y_cnt == CW'(V_RES - 1));
    assign res_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign handshake = res_valid & res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            de_q      <= 1'b0;
            vs_q      <= 1'b0;
            hs_q      <= 1'b0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
            acc_clr   <= 1'b0;
            acc_en    <= 1'b0;
            frame_cnt <= 8'd0;
            drop_cnt  <= 8'd0;
        end else begin
            de_q    <= vid_de;
            vs_q    <= vid_vs;
            hs_q    <= vid_hs;
            acc_clr <= 1'b0;
            acc_en  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable) state <= S_ARMED;
                end
                S_ARMED: begin
                    if (vs_rise) begin
                        acc_clr <= 1'b1;
                        x_cnt   <= '0;
                        y_cnt   <= '0;
                        state   <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    // acc_en and pix_x/pix_y register together so they stay aligned
                    acc_en <= vid_de & ~vs_rise;
                    if (vid_de) begin
                        pix_x <= x_cnt;
                        pix_y <= y_cnt;
                        x_cnt <= x_cnt + 1'b1;
                    end else if (de_fall) begin
                        x_cnt <= '0;
                        y_cnt <= y_cnt + 1'b1;
                        if (last_line) state <= S_DONE;
                    end else if (hs_rise) begin
                        x_cnt <= '0;
                    end
                    // a vsync before the last line closes a short frame
                    if (vs_rise) state <= S_DONE;
                end
                default: begin
                    if (handshake) begin
                        frame_cnt <= frame_cnt + 8'd1;
                        if (enable && vs_rise) begin
                            acc_clr <= 1'b1;
                            x_cnt   <= '0;
                            y_cnt   <= '0;
                            state   <= S_ACTIVE;
                        end else if (enable) begin
                            state <= S_ARMED;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (vs_rise && drop_cnt != 8'hFF) begin
                        // held result survives: no clear, just count the lost frame
                        drop_cnt <= drop_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

`ifdef BBOX_FRAME_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else if ((state == S_ACTIVE && ((de_fall && x_cnt != CW'(H_RES)) || vs_rise)) ||
                     (state == S_DONE && vid_de)) begin
            frame_err <= 1'b1;
        end
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_bbox_frame_ctrl.sv
// Directed bench for bbox_frame_ctrl using 64x64 timing (83 clk/line, 85 lines/frame).
module tb_bbox_frame_ctrl;

    localparam int CW = 11;

`ifdef BBOX_FRAME_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, enable, vid_de, vid_hs, vid_vs, res_ready;
    logic [CW-1:0] pix_x, pix_y;
    logic          acc_clr, acc_en, res_valid, busy, frame_err;
    logic [7:0]    frame_cnt, drop_cnt;

    int n_chk = 0, n_fail = 0;
    int en_cnt = 0, clr_cnt = 0, last_x = -1, last_y = -1, rv_viol = 0;
    logic prv_rv = 1'b0, prv_rdy = 1'b0;
    int c0, e0;

    bbox_frame_ctrl #(.H_RES(64), .V_RES(64), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs),
        .pix_x(pix_x), .pix_y(pix_y), .acc_clr(acc_clr), .acc_en(acc_en),
        .res_valid(res_valid), .res_ready(res_ready),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // event monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (acc_en === 1'b1) begin
            en_cnt = en_cnt + 1;
            last_x = int'(pix_x);
            last_y = int'(pix_y);
        end
        if (acc_clr === 1'b1) clr_cnt = clr_cnt + 1;
        if (rst_n && prv_rv && !prv_rdy && res_valid !== 1'b1) rv_viol = rv_viol + 1;
        prv_rv  = rst_n && (res_valid === 1'b1);
        prv_rdy = res_ready;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic de, input logic hs, input logic vs);
        vid_de = de; vid_hs = hs; vid_vs = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic tail(input int n);
        for (int i = 0; i < n; i++) step(1'b0, (i >= 2 && i < 6), 1'b0);
    endtask

    task automatic act_line(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
        tail(83 - n);
    endtask

    task automatic vblank_rest();
        for (int i = 0; i < 165; i++) step(1'b0, 1'b0, 1'b1);
        for (int l = 0; l < 19; l++) tail(83);
    endtask

    task automatic vblank();
        step(1'b0, 1'b0, 1'b1);
        vblank_rest();
    endtask

    task automatic mini();
        for (int i = 0; i < 166; i++) step(1'b0, 1'b0, 1'b1);
        tail(83);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; res_ready = 1'b0;
        vid_de = 1'b0; vid_hs = 1'b0; vid_vs = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_acc_clr", acc_clr, 0);
        chk("rst_acc_en", acc_en, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_pix_x", pix_x, 0);

        rst_n = 1'b1; enable = 1'b1; res_ready = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk("armed_busy", busy, 1);
        step(1'b0, 1'b0, 1'b0);

        // T1 normal frame
        c0 = clr_cnt; e0 = en_cnt;
        vblank();
        repeat (63) act_line(64);
        repeat (64) step(1'b1, 1'b0, 1'b0);
        chk("t1_rv_before_fall", res_valid, 0);
        step(1'b0, 1'b0, 1'b0);
        chk("t1_rv_after_fall", res_valid, 1);
        chk("t1_acc_en_done", acc_en, 0);
        step(1'b0, 1'b0, 1'b0);
        chk("t1_frame_cnt", frame_cnt, 1);
        chk("t1_rv_accepted", res_valid, 0);
        tail(17);
        chk("t1_clr_once", clr_cnt - c0, 1);
        chk("t1_en_cycles", en_cnt - e0, 4096);
        chk("t1_last_x", last_x, 63);
        chk("t1_last_y", last_y, 63);
        chk("t1_frame_err", frame_err, 0);

        // T2 stalled consumer
        res_ready = 1'b0;
        vblank();
        repeat (64) act_line(64);
        chk("t2_rv_held", res_valid, 1);
        c0 = clr_cnt;
        repeat (3) mini();
        chk("t2_drop_cnt", drop_cnt, 3);
        chk("t2_rv_still", res_valid, 1);
        chk("t2_no_clr", clr_cnt - c0, 0);
        chk("t2_frame_cnt_hold", frame_cnt, 1);
        res_ready = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk("t2_release_cnt", frame_cnt, 2);
        chk("t2_release_rv", res_valid, 0);
        res_ready = 1'b0;
        c0 = clr_cnt; e0 = en_cnt;
        vblank();
        repeat (64) act_line(64);
        chk("t2_next_en", en_cnt - e0, 4096);
        chk("t2_next_clr", clr_cnt - c0, 1);
        chk("t2_next_rv", res_valid, 1);
        chk("t2_next_cnt", frame_cnt, 2);

        // T6 handshake and vs_rise in the same cycle
        res_ready = 1'b1;
        e0 = en_cnt;
        step(1'b0, 1'b0, 1'b1);
        chk("t6_acc_clr", acc_clr, 1);
        chk("t6_frame_cnt", frame_cnt, 3);
        chk("t6_drop_cnt", drop_cnt, 3);
        chk("t6_rv", res_valid, 0);
        vblank_rest();
        repeat (64) act_line(64);
        chk("t6_captured_en", en_cnt - e0, 4096);
        chk("t6_frame_cnt_end", frame_cnt, 4);

        // T3 enable dropped mid-frame
        vblank();
        repeat (10) act_line(64);
        enable = 1'b0;
        repeat (54) act_line(64);
        chk("t3_frame_cnt", frame_cnt, 5);
        chk("t3_busy", busy, 0);
        c0 = clr_cnt;
        mini();
        chk("t3_no_clr", clr_cnt - c0, 0);
        chk("t3_idle", busy, 0);

        // T4 async reset at line 30
        enable = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        vblank();
        repeat (30) act_line(64);
        repeat (20) step(1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t4_acc_en", acc_en, 0);
        chk("t4_busy", busy, 0);
        chk("t4_rv", res_valid, 0);
        chk("t4_frame_cnt", frame_cnt, 0);
        chk("t4_pix_y", pix_y, 0);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        c0 = clr_cnt;
        repeat (41) step(1'b1, 1'b0, 1'b0);
        tail(19);
        repeat (33) act_line(64);
        chk("t4_no_clr_midframe", clr_cnt - c0, 0);
        chk("t4_armed", busy, 1);
        step(1'b0, 1'b0, 1'b1);
        chk("t4_clr_at_vs", acc_clr, 1);
        vblank_rest();
        step(1'b1, 1'b0, 1'b0);
        chk("t4_first_en", acc_en, 1);
        chk("t4_x0", pix_x, 0);
        chk("t4_y0", pix_y, 0);
        repeat (63) step(1'b1, 1'b0, 1'b0);
        tail(19);

        // T5 short line inside the same frame
        repeat (4) act_line(64);
        chk("t5_err_before", frame_err, 0);
        act_line(63);
        chk("t5_err_set", frame_err, EXP_ERR);
        repeat (58) act_line(64);
        chk("t5_frame_cnt", frame_cnt, 1);
        chk("t5_last_x", last_x, 63);
        chk("t5_last_y", last_y, 63);
        chk("t5_err_sticky", frame_err, EXP_ERR);
        chk("rv_never_dropped", rv_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
